// File: rtl/cpu_redundancy_switch_if.sv
// Bus bundle for cpu_redundancy_switch.
// Carries the per-channel health inputs, the command-switch strobe/index
// and the selection/status outputs of the switch.
//   io_ok      : per-channel health (1 = healthy), asynchronous to clk
//   force_swi  : single-cycle command-switch strobe
//   com_swi    : commanded channel index
//   sel        : active channel index
//   sel_valid  : 1 = sel is a healthy channel
//   sel_oh     : one-hot of sel, all zeros when sel_valid = 0
//   switch_evt : one-cycle pulse when sel or sel_valid changes
//   err_cnt    : packed per-channel error counters
interface cpu_redundancy_switch_if #(
    parameter int N_CPU = 2,
    parameter int SEL_W = 1,
    parameter int ERR_W = 8
);
    logic [N_CPU-1:0]       io_ok;
    logic                   force_swi;
    logic [SEL_W-1:0]       com_swi;
    logic [SEL_W-1:0]       sel;
    logic                   sel_valid;
    logic [N_CPU-1:0]       sel_oh;
    logic                   switch_evt;
    logic [N_CPU*ERR_W-1:0] err_cnt;

    modport master (
        output io_ok, force_swi, com_swi,
        input  sel, sel_valid, sel_oh, switch_evt, err_cnt
    );

    modport slave (
        input  io_ok, force_swi, com_swi,
        output sel, sel_valid, sel_oh, switch_evt, err_cnt
    );
endinterface

// File: rtl/cpu_redundancy_switch.sv
// Redundant CPU channel selector.
// Each channel's health input is synchronised and debounced; filtered fault
// onsets bump a per-channel error counter. An RUN/HOLD/DEAD FSM picks the
// active channel: fault failover, commanded switch, and error-count based
// preference switching with hysteresis, followed by a hold-off period.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of cpu_redundancy_switch_if (io_ok, force_swi,
//           com_swi in; sel, sel_valid, sel_oh, switch_evt, err_cnt out)
module cpu_redundancy_switch #(
    parameter int N_CPU    = 2,
    parameter int SEL_W    = 1,
    parameter int ERR_W    = 8,
    parameter int DEB_CYC  = 4,
    parameter int HOLD_CYC = 1024,
    parameter int HYST     = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    cpu_redundancy_switch_if.slave bus
);

    localparam int DEB_W  = 8;
    localparam int HOLD_W = 16;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        DEAD = 2'd2
    } state_t;

    // Input conditioning
    logic [N_CPU-1:0] sync1_q, sync2_q;
    logic [N_CPU-1:0] filt_q, filt_d;
    logic [N_CPU-1:0] filt_prev_q;
    logic [DEB_W-1:0] deb_q [N_CPU];
    logic [DEB_W-1:0] deb_d [N_CPU];
    logic [N_CPU-1:0] fall;

    // Error counters
    logic [ERR_W-1:0] cnt_q [N_CPU];
    logic [ERR_W-1:0] cnt_d [N_CPU];
    logic             ovf;

    // Selection FSM
    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              valid_q, valid_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              evt_q, evt_d;

    // Candidate evaluation
    logic             cur_ok;
    logic [ERR_W-1:0] cur_cnt;
    logic             found;
    logic [SEL_W-1:0] best;
    logic [ERR_W-1:0] best_cnt;
    logic             any_ok;
    logic [SEL_W-1:0] low_ok;
    logic             com_ok;
    logic             pref;

    logic [N_CPU-1:0]       oh;
    logic [N_CPU*ERR_W-1:0] err_pack;

    // Debounce: filtered value follows the synchronised sample only after
    // DEB_CYC consecutive samples disagreeing with it.
    always_comb begin
        filt_d = filt_q;
        for (int unsigned i = 0; i < N_CPU; i++) begin
            deb_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (deb_q[i] == DEB_W'(DEB_CYC - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    deb_d[i] = deb_q[i] + DEB_W'(1);
                end
            end
        end
    end

    assign fall = filt_prev_q & ~filt_q;

    // Counters: any increment that would land on all-ones halves every
    // counter first; a force strobe overrides everything with a clear.
    always_comb begin
        ovf = 1'b0;
        for (int unsigned i = 0; i < N_CPU; i++) begin
            if (fall[i] && ((cnt_q[i] + ERR_W'(1)) == {ERR_W{1'b1}})) begin
                ovf = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_CPU; i++) begin
            cnt_d[i] = (ovf ? (cnt_q[i] >> 1) : cnt_q[i]) + ERR_W'(fall[i]);
            if (bus.force_swi) begin
                cnt_d[i] = '0;
            end
        end
    end

    // Best candidate uses strict less-than so ties keep the lowest index.
    // com_ok can only be set for an in-range index since the loop stops at N_CPU.
    always_comb begin
        cur_ok   = 1'b0;
        cur_cnt  = '0;
        found    = 1'b0;
        best     = '0;
        best_cnt = '0;
        any_ok   = 1'b0;
        low_ok   = '0;
        com_ok   = 1'b0;
        for (int unsigned i = 0; i < N_CPU; i++) begin
            if (sel_q == SEL_W'(i)) begin
                cur_ok  = filt_q[i];
                cur_cnt = cnt_q[i];
            end
            if (filt_q[i] && (sel_q != SEL_W'(i)) && (!found || (cnt_q[i] < best_cnt))) begin
                found    = 1'b1;
                best     = SEL_W'(i);
                best_cnt = cnt_q[i];
            end
            if (filt_q[i] && !any_ok) begin
                any_ok = 1'b1;
                low_ok = SEL_W'(i);
            end
            if ((bus.com_swi == SEL_W'(i)) && filt_q[i] && (sel_q != SEL_W'(i))) begin
                com_ok = 1'b1;
            end
        end
        pref = found && (cur_cnt >= best_cnt) && ((cur_cnt - best_cnt) >= ERR_W'(HYST));
    end

    // Failover also applies in HOLD: staying on a faulted channel would
    // contradict sel_valid.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        unique case (state_q)
            RUN, HOLD: begin
                if (state_q == HOLD) begin
                    if (hold_q <= HOLD_W'(1)) begin
                        hold_d  = '0;
                        state_d = RUN;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                if (!cur_ok) begin
                    if (found) begin
                        sel_d   = best;
                        state_d = HOLD;
                        hold_d  = HOLD_W'(HOLD_CYC);
                    end else begin
                        valid_d = 1'b0;
                        state_d = DEAD;
                        hold_d  = '0;
                    end
                end else if (bus.force_swi && com_ok) begin
                    sel_d   = bus.com_swi;
                    state_d = HOLD;
                    hold_d  = HOLD_W'(HOLD_CYC);
                end else if ((state_q == RUN) && pref) begin
                    sel_d   = best;
                    state_d = HOLD;
                    hold_d  = HOLD_W'(HOLD_CYC);
                end
            end
            DEAD: begin
                if (any_ok) begin
                    sel_d   = low_ok;
                    valid_d = 1'b1;
                    state_d = HOLD;
                    hold_d  = HOLD_W'(HOLD_CYC);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        evt_d = (sel_d != sel_q) || (valid_d != valid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            filt_q      <= '1;
            filt_prev_q <= '1;
            for (int unsigned i = 0; i < N_CPU; i++) begin
                deb_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            state_q <= RUN;
            sel_q   <= '0;
            valid_q <= 1'b1;
            hold_q  <= '0;
            evt_q   <= 1'b0;
        end else begin
            sync1_q     <= bus.io_ok;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            for (int unsigned i = 0; i < N_CPU; i++) begin
                deb_q[i] <= deb_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            evt_q   <= evt_d;
        end
    end

    always_comb begin
        oh       = '0;
        err_pack = '0;
        for (int unsigned i = 0; i < N_CPU; i++) begin
            if (valid_q && (sel_q == SEL_W'(i))) begin
                oh[i] = 1'b1;
            end
            err_pack[i*ERR_W +: ERR_W] = cnt_q[i];
        end
    end

    assign bus.sel        = sel_q;
    assign bus.sel_valid  = valid_q;
    assign bus.sel_oh     = oh;
    assign bus.switch_evt = evt_q;
    assign bus.err_cnt    = err_pack;

endmodule

// File: tb/tb_cpu_redundancy_switch.sv
module tb_cpu_redundancy_switch;

    localparam int ST_RUN  = 0;
    localparam int ST_HOLD = 1;
    localparam int ST_DEAD = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_redundancy_switch_if #(.N_CPU(2), .SEL_W(1), .ERR_W(8)) bus_a ();
    cpu_redundancy_switch_if #(.N_CPU(3), .SEL_W(2), .ERR_W(8)) bus_b ();
    cpu_redundancy_switch_if #(.N_CPU(2), .SEL_W(1), .ERR_W(4)) bus_c ();

    cpu_redundancy_switch dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    cpu_redundancy_switch #(.N_CPU(3), .SEL_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    cpu_redundancy_switch #(.ERR_W(4), .HOLD_CYC(8)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    int checks = 0;
    int errors = 0;
    int evt_a = 0, evt_b = 0, evt_c = 0;

    always @(negedge clk) begin
        if (bus_a.switch_evt === 1'b1) evt_a++;
        if (bus_b.switch_evt === 1'b1) evt_b++;
        if (bus_c.switch_evt === 1'b1) evt_c++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus_a.io_ok = 2'b11;  bus_a.force_swi = 1'b0; bus_a.com_swi = '0;
        bus_b.io_ok = 3'b111; bus_b.force_swi = 1'b0; bus_b.com_swi = '0;
        bus_c.io_ok = 2'b11;  bus_c.force_swi = 1'b0; bus_c.com_swi = '0;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic pulse_b(input int ch, input int idle);
        bus_b.io_ok[ch] = 1'b0;
        cyc(7);
        bus_b.io_ok[ch] = 1'b1;
        cyc(8 + idle);
    endtask

    task automatic pulse_c(input int ch, input int idle);
        bus_c.io_ok[ch] = 1'b0;
        cyc(7);
        bus_c.io_ok[ch] = 1'b1;
        cyc(8 + idle);
    endtask

    typedef struct {
        logic [1:0] io;
        logic       frc;
        logic       com;
        int         n;
        logic       e_sel;
        logic       e_val;
        logic [1:0] e_oh;
        int         e_nevt;
        int         e_st;
        logic [7:0] e_c0;
        logic [7:0] e_c1;
    } vec_t;

    vec_t tbl [21];
    int   e0;

    initial begin
        // io,    frc,  com,  n, sel,  val,  oh,    nevt, state,  c0,   c1
        tbl[0]  = '{2'b11, 1'b0, 1'b0, 1, 1'b0, 1'b1, 2'b01, 0, ST_RUN,  8'd0, 8'd0};
        tbl[1]  = '{2'b10, 1'b0, 1'b0, 6, 1'b0, 1'b1, 2'b01, 0, ST_RUN,  8'd0, 8'd0};
        tbl[2]  = '{2'b10, 1'b0, 1'b0, 1, 1'b1, 1'b1, 2'b10, 1, ST_HOLD, 8'd1, 8'd0};
        tbl[3]  = '{2'b10, 1'b0, 1'b0, 1, 1'b1, 1'b1, 2'b10, 0, ST_HOLD, 8'd1, 8'd0};
        tbl[4]  = '{2'b11, 1'b0, 1'b0, 8, 1'b1, 1'b1, 2'b10, 0, ST_HOLD, 8'd1, 8'd0};
        tbl[5]  = '{2'b11, 1'b1, 1'b0, 1, 1'b0, 1'b1, 2'b01, 1, ST_HOLD, 8'd0, 8'd0};
        tbl[6]  = '{2'b11, 1'b0, 1'b0, 1, 1'b0, 1'b1, 2'b01, 0, ST_HOLD, 8'd0, 8'd0};
        tbl[7]  = '{2'b11, 1'b1, 1'b1, 1, 1'b1, 1'b1, 2'b10, 1, ST_HOLD, 8'd0, 8'd0};
        tbl[8]  = '{2'b00, 1'b0, 1'b0, 6, 1'b1, 1'b1, 2'b10, 0, ST_HOLD, 8'd0, 8'd0};
        tbl[9]  = '{2'b00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 2'b00, 1, ST_DEAD, 8'd1, 8'd1};
        tbl[10] = '{2'b00, 1'b0, 1'b0, 4, 1'b1, 1'b0, 2'b00, 0, ST_DEAD, 8'd1, 8'd1};
        tbl[11] = '{2'b10, 1'b0, 1'b0, 6, 1'b1, 1'b0, 2'b00, 0, ST_DEAD, 8'd1, 8'd1};
        tbl[12] = '{2'b10, 1'b0, 1'b0, 1, 1'b1, 1'b1, 2'b10, 1, ST_HOLD, 8'd1, 8'd1};
        tbl[13] = '{2'b10, 1'b0, 1'b0, 1, 1'b1, 1'b1, 2'b10, 0, ST_HOLD, 8'd1, 8'd1};
        tbl[14] = '{2'b11, 1'b0, 1'b0, 8, 1'b1, 1'b1, 2'b10, 0, ST_HOLD, 8'd1, 8'd1};
        tbl[15] = '{2'b01, 1'b0, 1'b0, 3, 1'b1, 1'b1, 2'b10, 0, ST_HOLD, 8'd1, 8'd1};
        tbl[16] = '{2'b11, 1'b0, 1'b0, 12, 1'b1, 1'b1, 2'b10, 0, ST_HOLD, 8'd1, 8'd1};
        tbl[17] = '{2'b11, 1'b1, 1'b0, 1, 1'b0, 1'b1, 2'b01, 1, ST_HOLD, 8'd0, 8'd0};
        tbl[18] = '{2'b01, 1'b0, 1'b0, 8, 1'b0, 1'b1, 2'b01, 0, ST_HOLD, 8'd0, 8'd1};
        tbl[19] = '{2'b01, 1'b1, 1'b1, 1, 1'b0, 1'b1, 2'b01, 0, ST_HOLD, 8'd0, 8'd0};
        tbl[20] = '{2'b01, 1'b0, 1'b0, 1, 1'b0, 1'b1, 2'b01, 0, ST_HOLD, 8'd0, 8'd0};

        // Reset values while rst_n is held low
        bus_a.io_ok = 2'b11;  bus_a.force_swi = 1'b0; bus_a.com_swi = '0;
        bus_b.io_ok = 3'b111; bus_b.force_swi = 1'b0; bus_b.com_swi = '0;
        bus_c.io_ok = 2'b11;  bus_c.force_swi = 1'b0; bus_c.com_swi = '0;
        rst_n = 1'b0;
        cyc(3);
        chk("rst_a_sel", bus_a.sel, 0);
        chk("rst_a_valid", bus_a.sel_valid, 1);
        chk("rst_a_oh", bus_a.sel_oh, 2'b01);
        chk("rst_a_evt", bus_a.switch_evt, 0);
        chk("rst_a_err", bus_a.err_cnt, 16'h0000);
        chk("rst_b_oh", bus_b.sel_oh, 3'b001);
        chk("rst_b_err", bus_b.err_cnt, 24'h000000);
        chk("rst_c_state", dut_c.state_q, ST_RUN);

        // Two-channel default instance: table of directed steps
        do_reset();
        for (int k = 0; k < 21; k++) begin
            bus_a.io_ok     = tbl[k].io;
            bus_a.force_swi = tbl[k].frc;
            bus_a.com_swi   = tbl[k].com;
            e0 = evt_a;
            cyc(tbl[k].n);
            chk($sformatf("a%0d_sel", k), bus_a.sel, tbl[k].e_sel);
            chk($sformatf("a%0d_valid", k), bus_a.sel_valid, tbl[k].e_val);
            chk($sformatf("a%0d_oh", k), bus_a.sel_oh, tbl[k].e_oh);
            chk($sformatf("a%0d_nevt", k), evt_a - e0, tbl[k].e_nevt);
            chk($sformatf("a%0d_state", k), dut_a.state_q, tbl[k].e_st);
            chk($sformatf("a%0d_cnt0", k), bus_a.err_cnt[7:0], tbl[k].e_c0);
            chk($sformatf("a%0d_cnt1", k), bus_a.err_cnt[15:8], tbl[k].e_c1);
        end
        bus_a.force_swi = 1'b0;

        // Three channels: counters {5,2,2}, tie on failover goes to ch1,
        // then no preference switch once back in RUN
        do_reset();
        e0 = evt_b;
        pulse_b(1, 0); pulse_b(1, 0);
        pulse_b(2, 0); pulse_b(2, 0);
        chk("b_cnt_pre", bus_b.err_cnt, {8'd2, 8'd2, 8'd0});
        chk("b_sel_pre", bus_b.sel, 0);
        chk("b_nevt_pre", evt_b - e0, 0);
        e0 = evt_b;
        pulse_b(0, 0);
        chk("b_tie_sel", bus_b.sel, 1);
        chk("b_tie_nevt", evt_b - e0, 1);
        for (int k = 0; k < 4; k++) pulse_b(0, 0);
        chk("b_cnt_522", bus_b.err_cnt, {8'd2, 8'd2, 8'd5});
        cyc(1100);
        chk("b_state_run", dut_b.state_q, ST_RUN);
        chk("b_sel_run", bus_b.sel, 1);
        e0 = evt_b;
        cyc(1024);
        chk("b_nopref_nevt", evt_b - e0, 0);
        chk("b_nopref_sel", bus_b.sel, 1);
        chk("b_nopref_state", dut_b.state_q, ST_RUN);

        // ERR_W=4: preference switch, overflow halving, reset mid-HOLD
        do_reset();
        for (int k = 0; k < 6; k++) pulse_c(1, 20);
        chk("c_cnt_ch1", bus_c.err_cnt, 8'h60);
        chk("c_sel_init", bus_c.sel, 0);
        e0 = evt_c;
        pulse_c(0, 20);
        chk("c_pref_nevt", evt_c - e0, 2);
        chk("c_pref_sel", bus_c.sel, 0);
        chk("c_cnt_61", bus_c.err_cnt, 8'h61);
        for (int k = 2; k <= 14; k++) pulse_c(0, 20);
        chk("c_cnt_6e", bus_c.err_cnt, 8'h6E);
        chk("c_sel_14", bus_c.sel, 1);
        pulse_c(0, 20);
        chk("c_cnt_halved", bus_c.err_cnt, 8'h38);
        chk("c_sel_15", bus_c.sel, 1);
        bus_c.io_ok[1] = 1'b0;
        e0 = evt_c;
        cyc(7);
        chk("c_fail_sel", bus_c.sel, 0);
        chk("c_fail_nevt", evt_c - e0, 1);
        chk("c_fail_state", dut_c.state_q, ST_HOLD);
        chk("c_fail_cnt", bus_c.err_cnt, 8'h48);
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk("c_rst_sel", bus_c.sel, 0);
        chk("c_rst_valid", bus_c.sel_valid, 1);
        chk("c_rst_oh", bus_c.sel_oh, 2'b01);
        chk("c_rst_evt", bus_c.switch_evt, 0);
        chk("c_rst_err", bus_c.err_cnt, 8'h00);
        chk("c_rst_state", dut_c.state_q, ST_RUN);
        bus_c.io_ok[1] = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        chk("c_post_state", dut_c.state_q, ST_RUN);
        chk("c_post_sel", bus_c.sel, 0);
        chk("c_post_oh", bus_c.sel_oh, 2'b01);
        chk("c_post_err", bus_c.err_cnt, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
